// File: rtl/onfi_regs_pkg.sv
// Shared definitions for the ONFI register bank: register offsets, STATUS layout and FSM encodings.
package onfi_regs_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_ADDR   = 2'd2;
  localparam logic [1:0] REG_CMD    = 2'd3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;

  localparam logic [15:0] VERSION_DEFAULT = 16'h0001;

  typedef enum logic {
    BUS_IDLE,
    BUS_RESP
  } bus_state_t;

  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_LAUNCH,
    CMD_WAIT
  } cmd_state_t;

  function automatic logic [31:0] status_word(input logic [15:0] version,
                                              input logic timeout,
                                              input logic done,
                                              input logic busy);
    logic [31:0] w;
    w = '0;
    w[31:16]        = version;
    w[STAT_TIMEOUT] = timeout;
    w[STAT_DONE]    = done;
    w[STAT_BUSY]    = busy;
    return w;
  endfunction

endpackage

// File: rtl/onfi_wb_regs.sv
// Wishbone classic register slave for the ONFI controller: CTRL/ADDR/CMD registers,
// command launch handshake to the engine and a watchdog on the outstanding operation.
module onfi_wb_regs
  import onfi_regs_pkg::*;
#(
  parameter int          MM_DATA_W   = 32,
  parameter int          MM_ADDR_W   = 8,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [15:0] VERSION     = VERSION_DEFAULT
) (
  input  logic                 mm_clk_i,
  input  logic                 mm_rst_n_i,
  input  logic                 mm_cyc_i,
  input  logic                 mm_stb_i,
  input  logic                 mm_we_i,
  input  logic [MM_ADDR_W-1:0] mm_addr_i,
  input  logic [MM_DATA_W-1:0] mm_dat_i,
  output logic [MM_DATA_W-1:0] mm_dat_o,
  output logic                 mm_ack_o,
  output logic                 mm_err_o,
  output logic [31:0]          ctrl_o,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic [31:0]          cmd_o,
  output logic [31:0]          cmd_addr_o,
  input  logic                 op_done_i
);

  localparam int             CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  bus_state_t           bus_state_reg;
  cmd_state_t           cmd_state_reg;
  logic [31:0]          ctrl_reg, addr_reg, cmd_reg;
  logic [MM_DATA_W-1:0] dat_reg;
  logic                 ack_reg, err_reg, cmd_valid_reg;
  logic                 done_reg, timeout_reg;
  logic [CNT_W-1:0]     cnt_reg;

  logic                 busy, addr_ok, take, reject, wr_ok, launch, status_rd;
  logic [1:0]           reg_sel;
  logic [MM_DATA_W-1:0] rd_data;

  assign busy    = (cmd_state_reg != CMD_IDLE);
  assign addr_ok = (mm_addr_i[MM_ADDR_W-1:4] == '0) && (mm_addr_i[1:0] == 2'b00);
  assign reg_sel = mm_addr_i[3:2];
  assign take    = (bus_state_reg == BUS_IDLE) && mm_cyc_i && mm_stb_i;
  assign reject  = !addr_ok ||
                   (mm_we_i && ((reg_sel == REG_STATUS) || ((reg_sel == REG_CMD) && busy)));
  assign wr_ok     = take && mm_we_i && !reject;
  assign launch    = wr_ok && (reg_sel == REG_CMD);
  assign status_rd = take && !mm_we_i && !reject && (reg_sel == REG_STATUS);

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_STATUS: rd_data = status_word(VERSION, timeout_reg, done_reg, busy);
      REG_CTRL:   rd_data = ctrl_reg;
      REG_ADDR:   rd_data = addr_reg;
      REG_CMD:    rd_data = cmd_reg;
      default:    rd_data = '0;
    endcase
  end

  // Bus FSM: one response cycle per accepted strobe, then a mandatory idle cycle.
  always_ff @(posedge mm_clk_i or negedge mm_rst_n_i) begin
    if (!mm_rst_n_i) begin
      bus_state_reg <= BUS_IDLE;
      ack_reg       <= 1'b0;
      err_reg       <= 1'b0;
      dat_reg       <= '0;
      ctrl_reg      <= '0;
      addr_reg      <= '0;
      cmd_reg       <= '0;
    end else begin
      case (bus_state_reg)
        BUS_IDLE: begin
          if (take) begin
            bus_state_reg <= BUS_RESP;
            ack_reg       <= !reject;
            err_reg       <= reject;
            dat_reg       <= (reject || mm_we_i) ? '0 : rd_data;
          end
          if (wr_ok) begin
            case (reg_sel)
              REG_CTRL: ctrl_reg <= mm_dat_i;
              REG_ADDR: addr_reg <= mm_dat_i;
              REG_CMD:  cmd_reg  <= mm_dat_i;
              default:  ;
            endcase
          end
        end
        default: begin
          bus_state_reg <= BUS_IDLE;
          ack_reg       <= 1'b0;
          err_reg       <= 1'b0;
          dat_reg       <= '0;
        end
      endcase
    end
  end

  // Command FSM; later assignments deliberately override the STATUS-read clear.
  always_ff @(posedge mm_clk_i or negedge mm_rst_n_i) begin
    if (!mm_rst_n_i) begin
      cmd_state_reg <= CMD_IDLE;
      cmd_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      if (status_rd) begin
        done_reg    <= 1'b0;
        timeout_reg <= 1'b0;
      end
      case (cmd_state_reg)
        CMD_IDLE: begin
          if (launch) begin
            cmd_state_reg <= CMD_LAUNCH;
            cmd_valid_reg <= 1'b1;
            cnt_reg       <= '0;
            done_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
          end
        end
        CMD_LAUNCH, CMD_WAIT: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if ((cmd_state_reg == CMD_WAIT) && op_done_i) begin
            cmd_state_reg <= CMD_IDLE;
            done_reg      <= 1'b1;
          end else if (cnt_reg == CNT_LAST) begin
            cmd_state_reg <= CMD_IDLE;
            cmd_valid_reg <= 1'b0;
            timeout_reg   <= 1'b1;
          end else if ((cmd_state_reg == CMD_LAUNCH) && cmd_ready_i) begin
            cmd_state_reg <= CMD_WAIT;
            cmd_valid_reg <= 1'b0;
          end
        end
        default: begin
          cmd_state_reg <= CMD_IDLE;
          cmd_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mm_dat_o    = dat_reg;
  assign mm_ack_o    = ack_reg;
  assign mm_err_o    = err_reg;
  assign ctrl_o      = ctrl_reg;
  assign cmd_valid_o = cmd_valid_reg;
  assign cmd_o       = cmd_reg;
  assign cmd_addr_o  = addr_reg;

endmodule

// File: tb/tb_onfi_wb_regs.sv
// Self-checking bench for onfi_wb_regs: directed register scenarios plus randomized bus/engine traffic
// compared every cycle against a behavioural model of the register bank.
module tb_onfi_wb_regs;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] mm_dat;
  logic        ack, err;
  logic [31:0] ctrl, cmd, cmd_addr;
  logic        cmd_valid;
  logic        ready = 1'b0, op_done = 1'b0;

  always #5 clk = ~clk;

  onfi_wb_regs #(.MM_DATA_W(32), .MM_ADDR_W(8), .TIMEOUT_CYC(TO), .VERSION(16'h0001)) dut (
    .mm_clk_i   (clk),
    .mm_rst_n_i (rst_n),
    .mm_cyc_i   (cyc),
    .mm_stb_i   (stb),
    .mm_we_i    (we),
    .mm_addr_i  (addr),
    .mm_dat_i   (wdat),
    .mm_dat_o   (mm_dat),
    .mm_ack_o   (ack),
    .mm_err_o   (err),
    .ctrl_o     (ctrl),
    .cmd_valid_o(cmd_valid),
    .cmd_ready_i(ready),
    .cmd_o      (cmd),
    .cmd_addr_o (cmd_addr),
    .op_done_i  (op_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;
  bit rand_env = 1'b0;
  int valid_cycles = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: register array, sticky flags, and elapsed cycles since launch.
  logic [31:0] m_regs [4];
  bit          m_resp, m_busy, m_hs, m_done, m_to;
  int          m_el;
  logic [31:0] e_dat;
  bit          e_ack, e_err;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_resp = 0; m_busy = 0; m_hs = 0; m_done = 0; m_to = 0; m_el = 0;
    e_dat = '0; e_ack = 0; e_err = 0;
  endtask

  task automatic model_step();
    logic [31:0] status_old;
    int          a, idx;
    bit          launch, st_rd;
    launch = 0;
    st_rd  = 0;
    status_old = {16'h0001, 13'b0, m_to, m_done, m_busy};
    e_ack = 0; e_err = 0; e_dat = '0;
    if (m_resp) begin
      m_resp = 0;
    end else if (cyc && stb) begin
      m_resp = 1;
      a   = int'(addr);
      idx = a / 4;
      if (a >= 16 || (a % 4) != 0) e_err = 1;
      else if (we) begin
        if (idx == 0 || (idx == 3 && m_busy)) e_err = 1;
        else begin
          e_ack = 1;
          m_regs[idx] = wdat;
          if (idx == 3) launch = 1;
        end
      end else begin
        e_ack = 1;
        e_dat = (idx == 0) ? status_old : m_regs[idx];
        if (idx == 0) st_rd = 1;
      end
    end
    if (launch) begin
      m_busy = 1; m_hs = 0; m_el = 0; m_done = 0; m_to = 0;
    end else begin
      if (st_rd) begin m_done = 0; m_to = 0; end
      if (m_busy) begin
        m_el++;
        if (m_hs && op_done) begin m_busy = 0; m_done = 1; end
        else if (m_el == TO) begin m_busy = 0; m_to = 1; end
        else if (!m_hs && ready) m_hs = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("ack", {31'b0, ack}, {31'b0, e_ack});
        check("err", {31'b0, err}, {31'b0, e_err});
        check("rdata", mm_dat, e_dat);
        check("ctrl_o", ctrl, m_regs[1]);
        check("cmd_addr_o", cmd_addr, m_regs[2]);
        check("cmd_o", cmd, m_regs[3]);
        check("cmd_valid_o", {31'b0, cmd_valid}, {31'b0, (m_busy && !m_hs)});
        if (cmd_valid) valid_cycles++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_env) begin
        ready   = ($urandom_range(0, 3) != 0);
        op_done = ($urandom_range(0, 7) == 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "bench time limit");
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input bit w, input logic [7:0] a, input logic [31:0] d, input bit hold,
                     output logic [31:0] rdat, output logic k, output logic e);
    cyc = 1; stb = 1; we = w; addr = a; wdat = d;
    @(posedge clk);
    #1;
    rdat = mm_dat; k = ack; e = err;
    if (!hold) begin cyc = 0; stb = 0; end
    @(posedge clk);
    #1;
    cyc = 0; stb = 0; we = 0;
    $display("bus %s addr=%h wdat=%h -> ack=%b err=%b rdat=%h", w ? "WR" : "RD", a, d, k, e, rdat);
    check("ack_xor_err", {31'b0, k ^ e}, 32'd1);
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] d;
    logic k, e;
    bus(1'b0, a, 32'h0, 1'b0, d, k, e);
    check({nm, "_ack"}, {31'b0, k}, 32'd1);
    check({nm, "_data"}, d, exp);
  endtask

  task automatic wr_chk(input logic [7:0] a, input logic [31:0] d, input bit exp_err, input string nm);
    logic [31:0] r;
    logic k, e;
    bus(1'b1, a, d, 1'b0, r, k, e);
    check({nm, "_err"}, {31'b0, e}, {31'b0, exp_err});
  endtask

  initial begin
    logic [31:0] r;
    logic        k, e;
    logic [7:0]  ra;
    bit          rw;

    @(posedge clk);
    #1;
    cmp_en = 1;
    cycles(2);
    rst_n = 1;
    cycles(1);

    // Reset values
    rd_chk(8'h00, 32'h0001_0000, "t1_status");
    rd_chk(8'h04, 32'h0000_0000, "t1_ctrl");

    // CTRL/ADDR readback
    wr_chk(8'h04, 32'h00c0ffee, 1'b0, "t2_wr_ctrl");
    wr_chk(8'h08, 32'h0000abcd, 1'b0, "t2_wr_addr");
    rd_chk(8'h04, 32'h00c0ffee, "t2_ctrl");
    rd_chk(8'h08, 32'h0000abcd, "t2_addr");

    // Launch with a stalled engine
    ready = 0;
    valid_cycles = 0;
    wr_chk(8'h0c, 32'h0000abca, 1'b0, "t3_launch");
    cycles(2);
    ready = 1;
    cycles(2);
    check("t3_valid_cycles", 32'(valid_cycles), 32'd4);
    rd_chk(8'h00, 32'h0001_0001, "t3_status_busy");
    wr_chk(8'h0c, 32'h00c0ffee, 1'b1, "t3_cmd_while_busy");
    rd_chk(8'h0c, 32'h0000abca, "t3_cmd_kept");

    // Completion and sticky clear
    op_done = 1;
    cycles(1);
    op_done = 0;
    rd_chk(8'h00, 32'h0001_0002, "t4_status_done");
    rd_chk(8'h00, 32'h0001_0000, "t4_status_cleared");

    // Watchdog expiry
    ready = 1;
    wr_chk(8'h0c, 32'h00001234, 1'b0, "t5_launch");
    cycles(TO - 1);
    rd_chk(8'h00, 32'h0001_0004, "t5_status_timeout");
    rd_chk(8'h00, 32'h0001_0000, "t5_status_cleared");

    // Rejected accesses and async reset mid-operation
    bus(1'b0, 8'h10, 32'h0, 1'b0, r, k, e);
    check("t6_rd10_err", {31'b0, e}, 32'd1);
    check("t6_rd10_ack", {31'b0, k}, 32'd0);
    bus(1'b1, 8'h00, 32'hdeadbeef, 1'b0, r, k, e);
    check("t6_wr0_err", {31'b0, e}, 32'd1);
    check("t6_wr0_ack", {31'b0, k}, 32'd0);
    wr_chk(8'h0c, 32'h000055aa, 1'b0, "t6_launch");
    cycles(2);
    #1;
    rst_n = 0;
    #1;
    check("t6_rst_ctrl", ctrl, 32'h0);
    check("t6_rst_cmd", cmd, 32'h0);
    check("t6_rst_cmd_addr", cmd_addr, 32'h0);
    check("t6_rst_valid", {31'b0, cmd_valid}, 32'h0);
    check("t6_rst_ack_err", {30'b0, ack, err}, 32'h0);
    check("t6_rst_rdata", mm_dat, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1;
    cycles(1);
    rd_chk(8'h04, 32'h0, "t6_ctrl_after_rst");
    rd_chk(8'h00, 32'h0001_0000, "t6_status_after_rst");

    // Randomized traffic against the model
    rand_env = 1;
    for (int i = 0; i < 400; i++) begin
      cycles($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0, 1:       ra = 8'h00;
        2:          ra = 8'h04;
        3:          ra = 8'h08;
        4, 5, 6, 7: ra = 8'h0c;
        8:          ra = 8'($urandom_range(0, 15)) | 8'd1;
        default:    ra = 8'($urandom_range(16, 255));
      endcase
      rw = ($urandom_range(0, 1) == 1);
      bus(rw, ra, $urandom, ($urandom_range(0, 3) == 0), r, k, e);
    end
    rand_env = 0;
    ready = 0;
    op_done = 0;
    cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
